// File: rtl/pbs_pkg.sv
// ---------------------------------------------------------------------------
// pbs_pkg
//   Shared definitions for the battle-system datapath.
//   - DEF_HP_W / DEF_MAX_HP : default HP width and full-health value
//   - state_t               : HP-drain FSM state encoding (S_IDLE/S_DRAIN/S_DONE)
//   - target_t              : which combatant a damage request hits
// ---------------------------------------------------------------------------
package pbs_pkg;

    localparam int DEF_HP_W   = 8;
    localparam int DEF_MAX_HP = 100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        TGT_PLAYER = 1'b0,
        TGT_AI     = 1'b1
    } target_t;

endpackage

// File: rtl/pbs_tick_div.sv
// ---------------------------------------------------------------------------
// pbs_tick_div
//   Rate divider that paces the HP drain animation. While en is high the
//   counter walks 0..TICK_DIV-1; tick is high during the cycle in which the
//   counter sits at TICK_DIV-1, and the counter wraps to 0 on that edge.
//   Ports:
//     clk     in  clock, posedge
//     resetn  in  synchronous active-low reset (counter -> 0)
//     clear   in  synchronous clear (counter -> 0), overrides en
//     en      in  count enable
//     tick    out 1 when en and counter == TICK_DIV-1
// ---------------------------------------------------------------------------
module pbs_tick_div #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic en,
    output logic tick
);

    // A TICK_DIV of 1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == CNT_LAST);

    // Free-running divider counter, held at zero whenever the drain is not active.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pbs_hp_drain.sv
// ---------------------------------------------------------------------------
// pbs_hp_drain
//   Holds player and AI hit points. Each accepted apply_ad/apply_pd request
//   drains the target's HP by one unit per divider tick until the requested
//   damage is spent or the target reaches 0, then pulses done for one cycle.
//   Ports:
//     clk         in   clock, posedge
//     resetn      in   synchronous active-low reset
//     start_game  in   reload both HP to MAX_HP, abort any drain (top priority)
//     apply_ad    in   damage the AI (wins if apply_pd is also high)
//     apply_pd    in   damage the player
//     damage      in   damage amount, sampled with the accepted request
//     busy        out  drain in progress; requests ignored
//     done        out  one-cycle pulse when the request is fully applied
//     hp_is_zero  out  player_hp == 0 || ai_hp == 0
//     player_hp   out  current player HP
//     ai_hp       out  current AI HP
// ---------------------------------------------------------------------------
module pbs_hp_drain
    import pbs_pkg::*;
#(
    parameter int HP_W     = DEF_HP_W,
    parameter int MAX_HP   = DEF_MAX_HP,
    parameter int TICK_DIV = 1_000_000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_game,
    input  logic            apply_ad,
    input  logic            apply_pd,
    input  logic [HP_W-1:0] damage,
    output logic            busy,
    output logic            done,
    output logic            hp_is_zero,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] ai_hp
);

    localparam logic [HP_W-1:0] HP_FULL = HP_W'(MAX_HP);
    localparam logic [HP_W-1:0] HP_ZERO = '0;
    localparam logic [HP_W-1:0] HP_ONE  = HP_W'(1);

    state_t          state;
    target_t         target;
    logic [HP_W-1:0] remaining;

    logic            tick;
    logic            div_clear;
    logic            div_en;

    target_t         req_target;
    logic [HP_W-1:0] req_hp;
    logic [HP_W-1:0] tgt_hp;
    logic [HP_W-1:0] other_hp;
    logic [HP_W-1:0] tgt_hp_dec;
    logic [HP_W-1:0] remaining_dec;

    // The divider only runs while draining; start_game must also zero it on
    // the abort edge rather than letting it advance one more step.
    assign div_en    = (state == S_DRAIN);
    assign div_clear = (state != S_DRAIN) || start_game;

    pbs_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .resetn (resetn),
        .clear  (div_clear),
        .en     (div_en),
        .tick   (tick)
    );

    // Request decode plus saturating "next" values for the latched target.
    // hp_is_zero is loaded from these so it moves on the same edge as the HP.
    always_comb begin
        req_target    = apply_ad ? TGT_AI : TGT_PLAYER;
        req_hp        = (req_target == TGT_AI) ? ai_hp : player_hp;
        tgt_hp        = (target == TGT_AI) ? ai_hp : player_hp;
        other_hp      = (target == TGT_AI) ? player_hp : ai_hp;
        tgt_hp_dec    = (tgt_hp == HP_ZERO) ? HP_ZERO : (tgt_hp - HP_ONE);
        remaining_dec = (remaining == HP_ZERO) ? HP_ZERO : (remaining - HP_ONE);
    end

    // Drain FSM with registered busy/done/hp_is_zero. start_game outranks
    // every state and never produces a done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            target     <= TGT_PLAYER;
            remaining  <= HP_ZERO;
            player_hp  <= HP_FULL;
            ai_hp      <= HP_FULL;
            busy       <= 1'b0;
            done       <= 1'b0;
            hp_is_zero <= 1'b0;
        end else if (start_game) begin
            state      <= S_IDLE;
            remaining  <= HP_ZERO;
            player_hp  <= HP_FULL;
            ai_hp      <= HP_FULL;
            busy       <= 1'b0;
            done       <= 1'b0;
            hp_is_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (apply_ad || apply_pd) begin
                        target    <= req_target;
                        remaining <= damage;
                        // Nothing to drain: report completion immediately.
                        if ((damage == HP_ZERO) || (req_hp == HP_ZERO)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                            busy  <= 1'b1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (tick) begin
                        if (target == TGT_AI) begin
                            ai_hp <= tgt_hp_dec;
                        end else begin
                            player_hp <= tgt_hp_dec;
                        end
                        remaining  <= remaining_dec;
                        hp_is_zero <= (tgt_hp_dec == HP_ZERO) || (other_hp == HP_ZERO);
                        if ((remaining_dec == HP_ZERO) || (tgt_hp_dec == HP_ZERO)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pbs_hp_drain.sv
// ---------------------------------------------------------------------------
// tb_pbs_hp_drain
//   Directed self-checking bench for pbs_hp_drain with TICK_DIV=4,
//   MAX_HP=100, HP_W=8. Cycle c means the interval after edge c-1, where
//   edge 0 is the edge that accepts the request.
// ---------------------------------------------------------------------------
module tb_pbs_hp_drain;

    logic       clk;
    logic       resetn;
    logic       start_game;
    logic       apply_ad;
    logic       apply_pd;
    logic [7:0] damage;
    logic       busy;
    logic       done;
    logic       hp_is_zero;
    logic [7:0] player_hp;
    logic [7:0] ai_hp;

    int checks;
    int passed;

    pbs_hp_drain #(
        .HP_W     (8),
        .MAX_HP   (100),
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_game (start_game),
        .apply_ad   (apply_ad),
        .apply_pd   (apply_pd),
        .damage     (damage),
        .busy       (busy),
        .done       (done),
        .hp_is_zero (hp_is_zero),
        .player_hp  (player_hp),
        .ai_hp      (ai_hp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        checks++; if (player_hp !== 8'd100) $display("[TB] FAIL reset_player_hp got %0d expected 100", player_hp); else passed++;
        checks++; if (ai_hp !== 8'd100) $display("[TB] FAIL reset_ai_hp got %0d expected 100", ai_hp); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %0b expected 0", done); else passed++;
        checks++; if (hp_is_zero !== 1'b0) $display("[TB] FAIL reset_hp_is_zero got %0b expected 0", hp_is_zero); else passed++;
        resetn = 1'b1;
        step();
    endtask

    // ai 100 -> 97, decrements at edges 4/8/12, done in cycle 13.
    task automatic test_attack_ai();
        logic [7:0] exp_ai;
        apply_ad = 1'b1;
        damage   = 8'd3;
        step();
        apply_ad = 1'b0;
        damage   = 8'd0;
        for (int c = 1; c <= 15; c++) begin
            exp_ai = 8'(100 - (((c - 1) / 4 > 3) ? 3 : (c - 1) / 4));
            checks++; if (ai_hp !== exp_ai) $display("[TB] FAIL ad_ai_hp cycle %0d got %0d expected %0d", c, ai_hp, exp_ai); else passed++;
            checks++; if (player_hp !== 8'd100) $display("[TB] FAIL ad_player_hp cycle %0d got %0d expected 100", c, player_hp); else passed++;
            checks++; if (busy !== (c <= 12)) $display("[TB] FAIL ad_busy cycle %0d got %0b expected %0b", c, busy, (c <= 12)); else passed++;
            checks++; if (done !== (c == 13)) $display("[TB] FAIL ad_done cycle %0d got %0b expected %0b", c, done, (c == 13)); else passed++;
            step();
        end
    endtask

    // player 100 with damage 120 saturates at 0 on edge 400.
    task automatic test_saturate();
        logic [7:0] exp_pl;
        int         n;
        apply_pd = 1'b1;
        damage   = 8'd120;
        step();
        apply_pd = 1'b0;
        damage   = 8'd0;
        for (int c = 1; c <= 403; c++) begin
            n      = ((c - 1) / 4 > 100) ? 100 : (c - 1) / 4;
            exp_pl = 8'(100 - n);
            checks++; if (player_hp !== exp_pl) $display("[TB] FAIL sat_player_hp cycle %0d got %0d expected %0d", c, player_hp, exp_pl); else passed++;
            checks++; if (ai_hp !== 8'd97) $display("[TB] FAIL sat_ai_hp cycle %0d got %0d expected 97", c, ai_hp); else passed++;
            checks++; if (busy !== (c <= 400)) $display("[TB] FAIL sat_busy cycle %0d got %0b expected %0b", c, busy, (c <= 400)); else passed++;
            checks++; if (done !== (c == 401)) $display("[TB] FAIL sat_done cycle %0d got %0b expected %0b", c, done, (c == 401)); else passed++;
            checks++; if (hp_is_zero !== (c >= 401)) $display("[TB] FAIL sat_hp_is_zero cycle %0d got %0b expected %0b", c, hp_is_zero, (c >= 401)); else passed++;
            step();
        end
    endtask

    // Target already at 0: immediate done, no drain.
    task automatic test_zero_target();
        apply_pd = 1'b1;
        damage   = 8'd5;
        step();
        apply_pd = 1'b0;
        damage   = 8'd0;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (done !== (c == 1)) $display("[TB] FAIL zt_done cycle %0d got %0b expected %0b", c, done, (c == 1)); else passed++;
            checks++; if (busy !== 1'b0) $display("[TB] FAIL zt_busy cycle %0d got %0b expected 0", c, busy); else passed++;
            checks++; if (player_hp !== 8'd0) $display("[TB] FAIL zt_player_hp cycle %0d got %0d expected 0", c, player_hp); else passed++;
            checks++; if (hp_is_zero !== 1'b1) $display("[TB] FAIL zt_hp_is_zero cycle %0d got %0b expected 1", c, hp_is_zero); else passed++;
            step();
        end
    endtask

    // start_game in IDLE with a simultaneous request: reload, request ignored.
    task automatic test_start_game();
        start_game = 1'b1;
        apply_pd   = 1'b1;
        damage     = 8'd9;
        step();
        start_game = 1'b0;
        apply_pd   = 1'b0;
        damage     = 8'd0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (player_hp !== 8'd100) $display("[TB] FAIL sg_player_hp cycle %0d got %0d expected 100", c, player_hp); else passed++;
            checks++; if (ai_hp !== 8'd100) $display("[TB] FAIL sg_ai_hp cycle %0d got %0d expected 100", c, ai_hp); else passed++;
            checks++; if (busy !== 1'b0) $display("[TB] FAIL sg_busy cycle %0d got %0b expected 0", c, busy); else passed++;
            checks++; if (done !== 1'b0) $display("[TB] FAIL sg_done cycle %0d got %0b expected 0", c, done); else passed++;
            checks++; if (hp_is_zero !== 1'b0) $display("[TB] FAIL sg_hp_is_zero cycle %0d got %0b expected 0", c, hp_is_zero); else passed++;
            step();
        end
    endtask

    // Both requests high: AI wins. A pd pulse while busy is dropped.
    task automatic test_both_requests();
        logic [7:0] exp_ai;
        apply_ad = 1'b1;
        apply_pd = 1'b1;
        damage   = 8'd5;
        step();
        apply_ad = 1'b0;
        apply_pd = 1'b0;
        damage   = 8'd0;
        for (int c = 1; c <= 24; c++) begin
            exp_ai = 8'(100 - (((c - 1) / 4 > 5) ? 5 : (c - 1) / 4));
            checks++; if (ai_hp !== exp_ai) $display("[TB] FAIL both_ai_hp cycle %0d got %0d expected %0d", c, ai_hp, exp_ai); else passed++;
            checks++; if (player_hp !== 8'd100) $display("[TB] FAIL both_player_hp cycle %0d got %0d expected 100", c, player_hp); else passed++;
            checks++; if (busy !== (c <= 20)) $display("[TB] FAIL both_busy cycle %0d got %0b expected %0b", c, busy, (c <= 20)); else passed++;
            checks++; if (done !== (c == 21)) $display("[TB] FAIL both_done cycle %0d got %0b expected %0b", c, done, (c == 21)); else passed++;
            if (c == 6) begin
                apply_pd = 1'b1;
                damage   = 8'd7;
            end else begin
                apply_pd = 1'b0;
                damage   = 8'd0;
            end
            step();
        end
    endtask

    // Zero damage: done in cycle 1, never busy, HP untouched.
    task automatic test_zero_damage();
        apply_ad = 1'b1;
        damage   = 8'd0;
        step();
        apply_ad = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (done !== (c == 1)) $display("[TB] FAIL zd_done cycle %0d got %0b expected %0b", c, done, (c == 1)); else passed++;
            checks++; if (busy !== 1'b0) $display("[TB] FAIL zd_busy cycle %0d got %0b expected 0", c, busy); else passed++;
            checks++; if (ai_hp !== 8'd95) $display("[TB] FAIL zd_ai_hp cycle %0d got %0d expected 95", c, ai_hp); else passed++;
            checks++; if (player_hp !== 8'd100) $display("[TB] FAIL zd_player_hp cycle %0d got %0d expected 100", c, player_hp); else passed++;
            step();
        end
    endtask

    // Drain player by 50, abort during cycle 30 via start_game or reset.
    task automatic test_abort(input logic use_reset);
        logic [7:0] exp_pl;
        apply_pd = 1'b1;
        damage   = 8'd50;
        step();
        apply_pd = 1'b0;
        damage   = 8'd0;
        for (int c = 1; c <= 30; c++) begin
            exp_pl = 8'(100 - (c - 1) / 4);
            checks++; if (player_hp !== exp_pl) $display("[TB] FAIL abort%0b_player_hp cycle %0d got %0d expected %0d", use_reset, c, player_hp, exp_pl); else passed++;
            checks++; if (busy !== 1'b1) $display("[TB] FAIL abort%0b_busy cycle %0d got %0b expected 1", use_reset, c, busy); else passed++;
            if (c == 30) begin
                if (use_reset) resetn = 1'b0;
                else           start_game = 1'b1;
            end
            step();
        end
        resetn     = 1'b1;
        start_game = 1'b0;
        for (int c = 31; c <= 36; c++) begin
            checks++; if (player_hp !== 8'd100) $display("[TB] FAIL abort%0b_after_player_hp cycle %0d got %0d expected 100", use_reset, c, player_hp); else passed++;
            checks++; if (ai_hp !== 8'd100) $display("[TB] FAIL abort%0b_after_ai_hp cycle %0d got %0d expected 100", use_reset, c, ai_hp); else passed++;
            checks++; if (busy !== 1'b0) $display("[TB] FAIL abort%0b_after_busy cycle %0d got %0b expected 0", use_reset, c, busy); else passed++;
            checks++; if (done !== 1'b0) $display("[TB] FAIL abort%0b_after_done cycle %0d got %0b expected 0", use_reset, c, done); else passed++;
            step();
        end
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        resetn     = 1'b0;
        start_game = 1'b0;
        apply_ad   = 1'b0;
        apply_pd   = 1'b0;
        damage     = 8'd0;
        #1;
        test_reset();
        test_attack_ai();
        test_saturate();
        test_zero_target();
        test_start_game();
        test_both_requests();
        test_zero_damage();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
